// File: rtl/frame_read_addr_gen_if.sv
// Frame read address generator bus: display-side controls in, SRAM
// address/strobe and status out.
interface frame_read_addr_gen_if #(
    parameter int ADDR_WIDTH = 20
);
    logic                  i_frame_start;
    logic                  i_buf_sel;
    logic                  i_pixel_en;
    logic [ADDR_WIDTH-1:0] o_sram_addr;
    logic                  o_sram_oe_n;
    logic                  o_load;
    logic                  o_frame_done;
    logic                  o_underrun;

    // Display timing side: drives frame/pixel controls, observes SRAM side.
    modport master (
        output i_frame_start, i_buf_sel, i_pixel_en,
        input  o_sram_addr, o_sram_oe_n, o_load, o_frame_done, o_underrun
    );

    // Address generator side.
    modport slave (
        input  i_frame_start, i_buf_sel, i_pixel_en,
        output o_sram_addr, o_sram_oe_n, o_load, o_frame_done, o_underrun
    );
endinterface

// File: rtl/frame_read_addr_gen.sv
// Walks one frame buffer in SRAM, one word per PIXEL_PER_ADDR pixels,
// paced by the display pixel enable. Emits a one-cycle load strobe each
// time a new word is on the SRAM bus, and supports double buffering.
module frame_read_addr_gen #(
    parameter int H_PIXELS       = 640,
    parameter int V_LINES        = 480,
    parameter int PIXEL_PER_ADDR = 4,
    parameter int ADDR_WIDTH     = 20,
    parameter int FRAME_BASE0    = 0,
    parameter int FRAME_BASE1    = 76800
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    frame_read_addr_gen_if.slave  bus
);
    localparam int W      = H_PIXELS * V_LINES / PIXEL_PER_ADDR;
    localparam int PIX_W  = (PIXEL_PER_ADDR > 1) ? $clog2(PIXEL_PER_ADDR) : 1;
    localparam int WORD_W = (W > 1) ? $clog2(W) : 1;

    localparam logic [PIX_W-1:0]      PIX_LAST  = PIX_W'(PIXEL_PER_ADDR - 1);
    localparam logic [WORD_W-1:0]     WORD_LAST = WORD_W'(W - 1);
    localparam logic [ADDR_WIDTH-1:0] BASE0     = ADDR_WIDTH'(FRAME_BASE0);
    localparam logic [ADDR_WIDTH-1:0] BASE1     = ADDR_WIDTH'(FRAME_BASE1);

    // A frame must not run past the top of the SRAM address space, and
    // the pixel counter relies on a power-of-2 word packing.
    if ((longint'(FRAME_BASE0) + longint'(W)) > (longint'(1) << ADDR_WIDTH)) begin : g_chk_base0
        $error("FRAME_BASE0 + W does not fit in ADDR_WIDTH");
    end
    if ((longint'(FRAME_BASE1) + longint'(W)) > (longint'(1) << ADDR_WIDTH)) begin : g_chk_base1
        $error("FRAME_BASE1 + W does not fit in ADDR_WIDTH");
    end
    if ((PIXEL_PER_ADDR < 1) || ((PIXEL_PER_ADDR & (PIXEL_PER_ADDR - 1)) != 0)) begin : g_chk_ppa
        $error("PIXEL_PER_ADDR must be a power of 2");
    end

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREFETCH = 2'd1,
        STREAM   = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [PIX_W-1:0]      pix_q, pix_d;
    logic [WORD_W-1:0]     word_q, word_d;
    logic                  load_q, load_d;
    logic                  done_q, done_d;
    logic                  underrun_q, underrun_d;

    // State and datapath registers; async reset returns every output to idle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            pix_q      <= '0;
            word_q     <= '0;
            load_q     <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            pix_q      <= pix_d;
            word_q     <= word_d;
            load_q     <= load_d;
            done_q     <= done_d;
            underrun_q <= underrun_d;
        end
    end

    // Next-state logic. Frame start overrides everything (including a
    // coincident pixel); load/done are registered so they line up with the
    // address they describe.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        pix_d      = pix_q;
        word_d     = word_q;
        load_d     = 1'b0;
        done_d     = 1'b0;
        underrun_d = underrun_q;

        if (bus.i_frame_start) begin
            state_d    = PREFETCH;
            addr_d     = bus.i_buf_sel ? BASE1 : BASE0;
            pix_d      = '0;
            word_d     = '0;
            underrun_d = 1'b0;
            load_d     = 1'b1;
        end else begin
            case (state_q)
                PREFETCH: begin
                    state_d = STREAM;
                    if (bus.i_pixel_en) underrun_d = 1'b1;
                end
                STREAM: begin
                    if (bus.i_pixel_en) begin
                        if (pix_q == PIX_LAST) begin
                            pix_d = '0;
                            if (word_q == WORD_LAST) begin
                                // Last word consumed: address holds at base+W-1.
                                state_d = DONE;
                                done_d  = 1'b1;
                            end else begin
                                addr_d = addr_q + ADDR_WIDTH'(1);
                                word_d = word_q + WORD_W'(1);
                                load_d = 1'b1;
                            end
                        end else begin
                            pix_d = pix_q + PIX_W'(1);
                        end
                    end
                end
                default: begin
                    if (bus.i_pixel_en) underrun_d = 1'b1;
                end
            endcase
        end
    end

    assign bus.o_sram_addr  = addr_q;
    assign bus.o_sram_oe_n  = !((state_q == PREFETCH) || (state_q == STREAM));
    assign bus.o_load       = load_q;
    assign bus.o_frame_done = done_q;
    assign bus.o_underrun   = underrun_q;

endmodule
